uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 27_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning serial bit rate.
REQ-003 SHALL have port clk, input, 1, system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port data_out, output, 8, last correctly framed received byte.
REQ-007 SHALL have port data_valid, output, 1, data_out holds an unread byte.
REQ-008 SHALL have port data_read, input, 1, one-cycle pulse from the consumer acknowledging data_out.
REQ-009 SHALL have port overrun, output, 1, sticky flag: a byte arrived while data_valid=1.
REQ-010 SHALL have port framing_error, output, 1, sticky flag: stop bit sampled low.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (reset value 1) before any use; rx_s denotes the synchronized value.
REQ-012 SHALL define BIT_TICKS = CLK_FREQ / BAUD_RATE (integer truncation) and HALF_TICKS = BIT_TICKS / 2.
REQ-013 SHALL implement the FSM states IDLE, START, DATA and STOP, with a tick counter wide enough for BIT_TICKS-1 and a 3-bit bit index.
REQ-014 IDLE: rx_s=0 -> START, counter cleared.
REQ-015 START: after HALF_TICKS cycles, sample rx_s; 1 -> IDLE (false start, no flags); 0 -> DATA, counter cleared, bit index 0.
REQ-016 DATA: every BIT_TICKS cycles, sample rx_s into the shift register, LSB first; after bit index 7 is sampled -> STOP.
REQ-017 STOP: after BIT_TICKS cycles, sample rx_s, then -> IDLE in the same cycle.
REQ-018 STOP sample = 1: load data_out with the shifted byte and set data_valid=1 on the next edge; if data_valid was already 1 and data_read is not asserted that cycle, also set overrun=1; data_out is overwritten with the new byte.
REQ-019 STOP sample = 0: data_out and data_valid are unchanged; set framing_error=1.
REQ-020 data_read=1 SHALL clear data_valid, overrun and framing_error on the next edge.
REQ-021 Simultaneous data_read and good-stop load: the load wins; data_valid stays 1, data_out holds the new byte, overrun stays 0.
REQ-022 data_read while data_valid=0 SHALL have no effect except clearing the sticky flags.
REQ-023 Latency: data_valid SHALL rise exactly 1 clk after the stop-bit sample cycle.
REQ-024 The receiver SHALL never stall; a new start bit is accepted from IDLE regardless of data_valid.
REQ-025 rx_s glitches in DATA/STOP between sample points SHALL be ignored (single sample per bit, no majority vote).

Reset
REQ-026 While rst_n=0: state IDLE, counter 0, bit index 0, shift register 0x00, data_out 0x00, data_valid 0, overrun 0, framing_error 0, synchronizer flops 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no output change after release; the next falling edge of rx_s starts a fresh frame.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000 -> BIT_TICKS=10, HALF_TICKS=5)
REQ-028 Send 0xA5 with a valid stop bit -> data_out=0xA5, data_valid=1 one cycle after the stop sample, flags 0; pulse data_read -> data_valid=0.
REQ-029 Send 0x3C then 0x81 without data_read -> data_out=0x81, data_valid=1, overrun=1; data_read -> all three cleared.
REQ-030 Send 0x55 with the stop bit held low -> framing_error=1, data_valid=0, data_out unchanged (0x00 after reset).
REQ-031 Drive rx low for 3 cycles, then high -> FSM back in IDLE, no data_valid, no flags.
REQ-032 Assert data_read in the same cycle as the good-stop sample of 0x7E, with a byte already pending -> data_valid=1, data_out=0x7E, overrun=0.
REQ-033 Assert rst_n=0 during bit 4 of a frame, release, then send 0xC3 -> data_out=0xC3, data_valid=1, no flags.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised input, mid-bit sampling, a one-byte holding register
// and sticky overrun / framing-error flags that the consumer clears with data_read.
module uart_rx #(
  parameter int CLK_FREQ  = 27_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_read,
  output logic       overrun,
  output logic       framing_error
);

  localparam int BIT_TICKS  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int CNT_W      = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((HALF_TICKS > 0) ? HALF_TICKS - 1 : 0);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic             rx_p0;
  logic             rx_s;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             stop_hit;
  logic             stop_good;
  logic             stop_bad;

  // Stage p0/p1: metastability synchroniser, idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
    end
  end

  // Frame sequencer: one sample per bit, taken at the middle of each bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt       <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_hit  = (state == STOP) && (cnt == BIT_LAST);
  assign stop_good = stop_hit && rx_s;
  assign stop_bad  = stop_hit && !rx_s;

  // Output holding register: a good stop load takes priority over a same-cycle read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out      <= 8'h00;
      data_valid    <= 1'b0;
      overrun       <= 1'b0;
      framing_error <= 1'b0;
    end else if (stop_good) begin
      data_out      <= shift_reg;
      data_valid    <= 1'b1;
      overrun       <= data_read ? 1'b0 : (overrun | data_valid);
      framing_error <= data_read ? 1'b0 : framing_error;
    end else begin
      if (data_read) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
      if (stop_bad)       framing_error <= 1'b1;
      else if (data_read) framing_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 1 MHz / 100 kbaud (10 clocks per bit, mid-bit sample at 5).
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_read;
  logic       overrun;
  logic       framing_error;

  int checks;
  int failures;

  uart_rx #(
    .CLK_FREQ (1_000_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_read    (data_read),
    .overrun      (overrun),
    .framing_error(framing_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start bit plus eight data bits, LSB first; returns at the negedge where the stop bit begins
  task automatic send_bits(input logic [7:0] b);
    rx = 1'b0;
    wait_neg(10);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_neg(10);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bits(b);
    rx = stop_bit;
    wait_neg(10);
    rx = 1'b1;
    wait_neg(2);
  endtask

  task automatic pulse_read();
    data_read = 1'b1;
    wait_neg(1);
    data_read = 1'b0;
    wait_neg(1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    rx        = 1'b1;
    data_read = 1'b0;
    wait_neg(5);
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", {7'd0, data_valid}, 8'd0);
    check("rst_overrun", {7'd0, overrun}, 8'd0);
    check("rst_ferr", {7'd0, framing_error}, 8'd0);
    rst_n = 1'b1;
    wait_neg(5);

    // Framing error on 0x55 straight after reset
    send_frame(8'h55, 1'b0);
    wait_neg(15);
    check("ferr_flag", {7'd0, framing_error}, 8'd1);
    check("ferr_valid", {7'd0, data_valid}, 8'd0);
    check("ferr_data_out", data_out, 8'h00);
    pulse_read();
    check("ferr_cleared", {7'd0, framing_error}, 8'd0);
    check("ferr_read_valid", {7'd0, data_valid}, 8'd0);
    wait_neg(5);

    // 0xA5 with exact latency: stop sample lands on the 8th rising edge after the stop bit starts
    send_bits(8'hA5);
    rx = 1'b1;
    wait_neg(7);
    check("a5_valid_before", {7'd0, data_valid}, 8'd0);
    wait_neg(1);
    check("a5_valid_after", {7'd0, data_valid}, 8'd1);
    check("a5_data_out", data_out, 8'hA5);
    check("a5_overrun", {7'd0, overrun}, 8'd0);
    check("a5_ferr", {7'd0, framing_error}, 8'd0);
    wait_neg(4);
    pulse_read();
    check("a5_read_valid", {7'd0, data_valid}, 8'd0);
    check("a5_read_data", data_out, 8'hA5);
    wait_neg(5);

    // Overrun: 0x3C then 0x81 without reading
    send_frame(8'h3C, 1'b1);
    check("ov_first_valid", {7'd0, data_valid}, 8'd1);
    check("ov_first_data", data_out, 8'h3C);
    check("ov_first_flag", {7'd0, overrun}, 8'd0);
    send_frame(8'h81, 1'b1);
    check("ov_data_out", data_out, 8'h81);
    check("ov_valid", {7'd0, data_valid}, 8'd1);
    check("ov_flag", {7'd0, overrun}, 8'd1);
    pulse_read();
    check("ov_clr_valid", {7'd0, data_valid}, 8'd0);
    check("ov_clr_flag", {7'd0, overrun}, 8'd0);
    check("ov_clr_ferr", {7'd0, framing_error}, 8'd0);
    wait_neg(5);

    // Read coincident with the good stop sample of 0x7E while 0x11 is pending
    send_frame(8'h11, 1'b1);
    check("coin_pending", {7'd0, data_valid}, 8'd1);
    send_bits(8'h7E);
    rx = 1'b1;
    wait_neg(7);
    data_read = 1'b1;
    wait_neg(1);
    data_read = 1'b0;
    check("coin_valid", {7'd0, data_valid}, 8'd1);
    check("coin_data", data_out, 8'h7E);
    check("coin_overrun", {7'd0, overrun}, 8'd0);
    wait_neg(4);
    pulse_read();
    wait_neg(5);

    // False start: line low for only 3 clocks
    rx = 1'b0;
    wait_neg(3);
    rx = 1'b1;
    wait_neg(20);
    check("fs_state_idle", {6'd0, dut.state}, 8'd0);
    check("fs_valid", {7'd0, data_valid}, 8'd0);
    check("fs_overrun", {7'd0, overrun}, 8'd0);
    check("fs_ferr", {7'd0, framing_error}, 8'd0);

    // Reset during bit 4, then a clean 0xC3
    rx = 1'b0;
    wait_neg(10);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 0) ? 1'b0 : 1'b1;
      wait_neg(10);
    end
    rx = 1'b1;
    wait_neg(5);
    rst_n = 1'b0;
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(2);
    check("mid_rst_valid", {7'd0, data_valid}, 8'd0);
    check("mid_rst_data", data_out, 8'h00);
    wait_neg(20);
    check("mid_rst_idle_valid", {7'd0, data_valid}, 8'd0);
    send_frame(8'hC3, 1'b1);
    check("c3_data_out", data_out, 8'hC3);
    check("c3_valid", {7'd0, data_valid}, 8'd1);
    check("c3_overrun", {7'd0, overrun}, 8'd0);
    check("c3_ferr", {7'd0, framing_error}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
